// File: rtl/ex_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS core: EX bypass selects, load-use stall,
// branch flush and the run/drain/halt FSM. Define PERF_CNT_EN to build the performance counters.
module ex_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_syscall,

  input  logic [4:0]       RW2,
  input  logic             RegWrite2,
  input  logic             MemRead2,
  input  logic [4:0]       RW3,
  input  logic             RegWrite3,
  input  logic             MemToReg3,

  input  logic             NewBranch,
  input  logic             Jump2,
  input  logic             SysCall3,
  input  logic             Halt3,
  input  logic             resume,

  output logic [1:0]       Bypass1,
  output logic [1:0]       Bypass2,
  output logic [1:0]       Bypass3,
  output logic [1:0]       Bypass4,
  output logic             NewHalt,
  output logic             stall,
  output logic             clear_id,
  output logic             clear_ex,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] SelRf     = 2'b00;
  localparam logic [1:0] SelMemNm  = 2'b01;
  localparam logic [1:0] SelWbNm   = 2'b10;
  localparam logic [1:0] SelWbData = 2'b11;

  localparam int unsigned   DrainW    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [3:0][1:0]   byp_q, byp_d;

  logic       flush;
  logic       load_use;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;
  logic [1:0] sel_a0;

  // Bypass select for one source; an EX-stage load never forwards (handled as load-use).
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic used);
    logic [1:0] sel;
    sel = SelRf;
    if (used && (r != 5'd0)) begin
      if (RegWrite2 && (RW2 == r) && !MemRead2) begin
        sel = SelMemNm;
      end else if (RegWrite3 && (RW3 == r)) begin
        sel = MemToReg3 ? SelWbData : SelWbNm;
      end
    end
    return sel;
  endfunction

  function automatic logic lu_hit(input logic [4:0] r, input logic used);
    return used && (r != 5'd0) && RegWrite2 && MemRead2 && (RW2 == r);
  endfunction

  always_comb begin
    sel_src1 = fwd_sel(id_src1, id_use1);
    sel_src2 = fwd_sel(id_src2, id_use2);
    sel_a0   = fwd_sel(5'd4, id_syscall);
    load_use = lu_hit(id_src1, id_use1) | lu_hit(id_src2, id_use2) | lu_hit(5'd4, id_syscall);
    flush    = NewBranch | Jump2;
  end

  // Pipeline control outputs; flush wins over load-use, HALTED freezes everything.
  always_comb begin
    NewHalt  = 1'b0;
    stall    = 1'b0;
    clear_id = 1'b0;
    clear_ex = 1'b0;
    if (!rst_n) begin
      clear_id = 1'b1;
      clear_ex = 1'b1;
    end else if (state_q != StHalted) begin
      NewHalt = 1'b1;
      if (flush) begin
        clear_id = 1'b1;
        clear_ex = 1'b1;
      end else if (load_use) begin
        stall    = 1'b1;
        clear_ex = 1'b1;
      end
      if (state_q == StDrain) begin
        clear_id = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StRun: begin
        if (SysCall3 && Halt3) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      StHalted: begin
        if (resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    byp_d = byp_q;
    if (NewHalt) begin
      if (flush || load_use) begin
        byp_d = '0;
      end else begin
        byp_d[0] = sel_src1;
        byp_d[1] = sel_src2;
        byp_d[2] = sel_src2;
        byp_d[3] = sel_a0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      drain_q <= '0;
      byp_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      byp_q   <= byp_d;
    end
  end

  assign Bypass1 = byp_q[0];
  assign Bypass2 = byp_q[1];
  assign Bypass3 = byp_q[2];
  assign Bypass4 = byp_q[3];

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // NewHalt is low in HALTED and in reset, so every counter holds there.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + CNT_W'(NewHalt);
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(NewHalt & flush);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: directed test-plan cases then random stimulus against a
// cycle-level reference model (producer lookup, drain countdown, counters).
module tb_ex_hazard_ctrl;

  localparam int unsigned DrainCycles = 2;
  localparam int unsigned CntW        = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      id_src1, id_src2;
  logic            id_use1, id_use2, id_syscall;
  logic [4:0]      RW2, RW3;
  logic            RegWrite2, MemRead2, RegWrite3, MemToReg3;
  logic            NewBranch, Jump2, SysCall3, Halt3, resume;
  logic [1:0]      Bypass1, Bypass2, Bypass3, Bypass4;
  logic            NewHalt, stall, clear_id, clear_ex;
  logic [CntW-1:0] cycle_cnt, stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(
    .DRAIN_CYCLES(DrainCycles),
    .CNT_W       (CntW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_src1   (id_src1),
    .id_src2   (id_src2),
    .id_use1   (id_use1),
    .id_use2   (id_use2),
    .id_syscall(id_syscall),
    .RW2       (RW2),
    .RegWrite2 (RegWrite2),
    .MemRead2  (MemRead2),
    .RW3       (RW3),
    .RegWrite3 (RegWrite3),
    .MemToReg3 (MemToReg3),
    .NewBranch (NewBranch),
    .Jump2     (Jump2),
    .SysCall3  (SysCall3),
    .Halt3     (Halt3),
    .resume    (resume),
    .Bypass1   (Bypass1),
    .Bypass2   (Bypass2),
    .Bypass3   (Bypass3),
    .Bypass4   (Bypass4),
    .NewHalt   (NewHalt),
    .stall     (stall),
    .clear_id  (clear_id),
    .clear_ex  (clear_ex),
    .cycle_cnt (cycle_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [1:0]      m_byp [4];
  bit              m_halted;
  int              m_drain;   // drain cycles still to run; 0 when not draining
  logic [CntW-1:0] m_cycle, m_stall, m_flush;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Which stage supplies register r: -1 pending load in EX, else the select code.
  function automatic int who(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (RegWrite2 && RW2 == r) return MemRead2 ? -1 : 1;
    if (RegWrite3 && RW3 == r) return MemToReg3 ? 3 : 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_byp[i] = 2'b00;
    m_halted = 1'b0;
    m_drain  = 0;
    m_cycle  = '0;
    m_stall  = '0;
    m_flush  = '0;
  endtask

  task automatic idle();
    rst_n = 1'b1;
    id_src1 = '0; id_src2 = '0; id_use1 = 0; id_use2 = 0; id_syscall = 0;
    RW2 = '0; RegWrite2 = 0; MemRead2 = 0;
    RW3 = '0; RegWrite3 = 0; MemToReg3 = 0;
    NewBranch = 0; Jump2 = 0; SysCall3 = 0; Halt3 = 0; resume = 0;
  endtask

  // Called just after a negedge with inputs applied: check, clock, advance the model.
  task automatic step();
    int s [4];
    bit lu, br;
    bit e_nh, e_st, e_ci, e_ce;
    #1;
    s[0] = id_use1 ? who(id_src1) : 0;
    s[1] = id_use2 ? who(id_src2) : 0;
    s[2] = s[1];
    s[3] = id_syscall ? who(5'd4) : 0;
    lu = (s[0] < 0) || (s[1] < 0) || (s[3] < 0);
    br = NewBranch || Jump2;
    if (!rst_n) begin
      e_nh = 0; e_st = 0; e_ci = 1; e_ce = 1;
    end else if (m_halted) begin
      e_nh = 0; e_st = 0; e_ci = 0; e_ce = 0;
    end else begin
      e_nh = 1;
      e_st = lu && !br;
      e_ci = br || (m_drain > 0);
      e_ce = br || lu;
    end
    check_eq("NewHalt", 64'(NewHalt), 64'(e_nh));
    check_eq("stall", 64'(stall), 64'(e_st));
    check_eq("clear_id", 64'(clear_id), 64'(e_ci));
    check_eq("clear_ex", 64'(clear_ex), 64'(e_ce));
    check_eq("Bypass1", 64'(Bypass1), 64'(m_byp[0]));
    check_eq("Bypass2", 64'(Bypass2), 64'(m_byp[1]));
    check_eq("Bypass3", 64'(Bypass3), 64'(m_byp[2]));
    check_eq("Bypass4", 64'(Bypass4), 64'(m_byp[3]));
`ifdef PERF_CNT_EN
    check_eq("cycle_cnt", 64'(cycle_cnt), 64'(m_cycle));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
    check_eq("cycle_cnt", 64'(cycle_cnt), 64'd0);
    check_eq("stall_cnt", 64'(stall_cnt), 64'd0);
    check_eq("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) m_byp[i] = (br || lu) ? 2'b00 : 2'(s[i]);
      m_cycle = m_cycle + 1;
      if (lu && !br) m_stall = m_stall + 1;
      if (br) m_flush = m_flush + 1;
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1'b1;
      end else if (SysCall3 && Halt3) begin
        m_drain = int'(DrainCycles);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 6))
      0: return 5'd0;
      1: return 5'd4;
      2: return 5'd8;
      3: return 5'd9;
      4: return 5'd10;
      5: return 5'd12;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_in();
    rst_n      = ($urandom_range(0, 49) != 0);
    id_src1    = pick_reg();
    id_src2    = pick_reg();
    id_use1    = 1'($urandom_range(0, 3) != 0);
    id_use2    = 1'($urandom_range(0, 3) != 0);
    id_syscall = 1'($urandom_range(0, 5) == 0);
    RW2        = pick_reg();
    RegWrite2  = 1'($urandom_range(0, 1));
    MemRead2   = 1'($urandom_range(0, 3) == 0);
    RW3        = pick_reg();
    RegWrite3  = 1'($urandom_range(0, 1));
    MemToReg3  = 1'($urandom_range(0, 1));
    NewBranch  = 1'($urandom_range(0, 9) == 0);
    Jump2      = 1'($urandom_range(0, 14) == 0);
    SysCall3   = 1'($urandom_range(0, 14) == 0);
    Halt3      = 1'($urandom_range(0, 1));
    resume     = 1'($urandom_range(0, 5) == 0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step();                                            // reset state, rst_n still low
    idle();

    RegWrite2 = 1; RW2 = 5'd8; id_src1 = 5'd8; id_use1 = 1;
    step(); idle(); step();                            // Bypass1 = 01

    RegWrite3 = 1; RW3 = 5'd9; MemToReg3 = 1; id_src2 = 5'd9; id_use2 = 1;
    step();                                            // Bypass2/3 = 11
    MemToReg3 = 0;
    step(); idle(); step();                            // Bypass2/3 = 10

    RegWrite2 = 1; MemRead2 = 1; RW2 = 5'd10; id_src1 = 5'd10; id_use1 = 1;
    step();                                            // load-use stall
    RegWrite2 = 0; MemRead2 = 0; RegWrite3 = 1; RW3 = 5'd10; MemToReg3 = 1;
    step(); idle(); step();                            // Bypass1 = 11

    RegWrite2 = 1; MemRead2 = 1; RW2 = 5'd10; id_src1 = 5'd10; id_use1 = 1; NewBranch = 1;
    step(); idle();                                    // flush beats stall
    RegWrite2 = 1; RW2 = 5'd0; RegWrite3 = 1; RW3 = 5'd0; id_src1 = 5'd0; id_use1 = 1;
    step(); idle(); step();                            // $0 never forwarded

    RegWrite2 = 1; RW2 = 5'd4; RegWrite3 = 1; RW3 = 5'd4; id_syscall = 1;
    step(); idle(); step();                            // Bypass4 = 01

    SysCall3 = 1; Halt3 = 1;
    step(); idle();
    repeat (4) step();                                 // drain 2 cycles, then halted
    resume = 1;
    step(); idle();
    step(); step();

    SysCall3 = 1; Halt3 = 1;
    step(); idle();
    step();
    rst_n = 1'b0;
    step(); idle();                                    // reset mid-drain
    step(); step();

    for (int n = 0; n < 3000; n++) begin
      rand_in();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
